winner_detect_seq: RTL and testbench
====================================

Name: winner_detect_seq

Overview:
- Sequential, parametrised successor to the combinational 4-channel one-hot winner decoder in the network output stage.
- Monitors N channels of W-bit activations and finds the channel that is the only nonzero one.
- Declares that channel the winner only after it stays the sole active channel for STABLE consecutive valid samples.
- Holds the result until the consumer acknowledges it, and gives up with a timeout flag after MAX_ITER samples.

Parameters:
- N, 4: number of channels; must be 2 or more.
- W, 5: bits per channel.
- STABLE, 3: consecutive identical one-hot samples required to declare a winner; must be 1 or more.
- MAX_ITER, 16: accepted samples before a timeout is declared; must be at least STABLE.
- IW, $clog2(N): index width (derived; not overridden).
- CW, $clog2(MAX_ITER+1): iteration counter width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle pulse that begins a detection run.
- in_valid  in  1  in_data holds a sample this cycle.
- in_data  in  N*W  channel c occupies bits [c*W +: W].
- ack  in  1  consumer has taken the result.
- busy  out  1  high in state TRACK.
- done  out  1  result valid; held until ack.
- timeout  out  1  qualifies done: the run ended without a winner.
- idx  out  IW  winning channel index; 0 when timeout=1.
- iter_count  out  CW  valid samples accepted in the current or last run.

Behaviour:
- Interface decision: one clock, clk. Reset is rst_n, synchronous and active-low. All state changes on the clk rising edge; all outputs are registered.
- Reset (rst_n=0 at a clock edge): state=IDLE; busy=0, done=0, timeout=0, idx=0, iter_count=0; streak=0, cand=0. Reset wins over every other input, including mid-run and during DONE.
- Combinational per sample:
  - act[c] = OR-reduce of channel c.
  - onehot = exactly one bit of act is set.
  - enc = index of that set bit.
- State IDLE:
  - start=1 -> TRACK; streak=0, iter_count=0, timeout=0, idx=0.
  - in_valid is ignored in IDLE.
- State TRACK (busy=1), on each cycle with in_valid=1:
  - iter_count increments.
  - If onehot and enc==cand and streak>0: streak increments.
  - Else if onehot: cand=enc, streak=1.
  - Else (zero or two-plus active channels): streak=0.
  - If the updated streak equals STABLE: -> DONE, done=1, idx=cand, timeout=0.
  - Else if the updated iter_count equals MAX_ITER: -> DONE, done=1, timeout=1, idx=0.
  - A winner has priority over a timeout on the same sample.
  - Cycles with in_valid=0 change nothing.
  - start while in TRACK is ignored.
- Latency: done rises on the clock edge that accepts the STABLE-th qualifying sample. Minimum is STABLE valid cycles after start.
- State DONE:
  - done, idx, timeout and iter_count hold steady.
  - ack=1 -> IDLE, done=0 on the next edge.
  - ack=1 together with start=1 -> TRACK directly; counters clear and done=0 (back-to-back runs).
  - start without ack is ignored.
- Widths and saturation:
  - iter_count never exceeds MAX_ITER.
  - streak is $clog2(STABLE+1) bits wide and never exceeds STABLE.
- Boundaries:
  - STABLE=1 behaves as the combinational decoder plus a handshake.
  - All-zero samples and multi-hot samples both break the streak.
  - A change of candidate restarts the streak at 1, not 0.
  - If channel N-1 is the sole active channel, idx=N-1.

Decomposition:
- Shared constants header: state encodings IDLE=2'd0, TRACK=2'd1, DONE=2'd2.
- One combinational sub-module, onehot_resolve (params N, W):
  - input: in_data.
  - outputs: act, onehot, enc.
  - It replaces the fixed 4-channel gate network and is reusable elsewhere.
- The top level holds the FSM, streak counter, iteration counter and output registers.

Test Plan (N=4, W=5, STABLE=3, MAX_ITER=8):
- Clean win: start, then 3 valid samples with only ch2=5'h07 -> done=1 on the 3rd accept edge, idx=2, timeout=0, iter_count=3; hold 4 cycles, then ack -> done=0, IDLE.
- Streak break: ch1 alone, ch1 alone, ch1+ch3 both nonzero, ch1 alone ×3 -> done after the 6th sample, idx=1, iter_count=6.
- Candidate switch plus gaps: ch0, ch0, ch3, ch3, ch3 with in_valid=0 bubbles between samples -> idx=3, iter_count=5; bubbles change nothing.
- Timeout: 8 all-zero samples -> done=1, timeout=1, idx=0, iter_count=8. Also run a sequence that reaches streak 3 exactly on sample 8 -> winner, timeout=0.
- Back-to-back: in DONE, ack and start in the same cycle -> TRACK next cycle with done=0 and iter_count=0. Then a ch0 win with idx=0.
- Reset mid-run: rst_n=0 for 1 cycle after 2 ch1 samples -> all outputs 0, IDLE. The next start needs a full 3-sample streak before done.

Source files
------------

// File: rtl/winner_detect_seq_pkg.sv
// Shared types and width helpers for the sequential one-hot winner detector.
package winner_detect_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/winner_detect_seq_onehot_resolve.sv
// Per-channel activity, exactly-one-active flag and index of the active channel.
module onehot_resolve #(
    parameter  int unsigned N  = 4,
    parameter  int unsigned W  = 5,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   act,
    output logic           onehot,
    output logic [IW-1:0]  enc
);

    always_comb begin
        act = '0;
        for (int c = 0; c < int'(N); c++) begin
            act[c] = |in_data[c*W +: W];
        end
    end

    // enc is only meaningful when onehot is set; otherwise it holds the highest active index.
    always_comb begin
        logic any;
        logic multi;
        any   = 1'b0;
        multi = 1'b0;
        enc   = '0;
        for (int c = 0; c < int'(N); c++) begin
            if (act[c]) begin
                multi = multi | any;
                any   = 1'b1;
                enc   = IW'(c);
            end
        end
        onehot = any & ~multi;
    end

endmodule

// File: rtl/winner_detect_seq.sv
// Declares the sole active channel a winner once it persists for STABLE valid samples,
// with an ack handshake and a MAX_ITER sample timeout.
module winner_detect_seq
    import winner_detect_seq_pkg::*;
#(
    parameter  int unsigned N        = 4,
    parameter  int unsigned W        = 5,
    parameter  int unsigned STABLE   = 3,
    parameter  int unsigned MAX_ITER = 16,
    localparam int unsigned IW       = $clog2(N),
    localparam int unsigned CW       = $clog2(MAX_ITER + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic           ack,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    output logic [IW-1:0]  idx,
    output logic [CW-1:0]  iter_count
);

    localparam int unsigned SW = cnt_width(STABLE);

    state_t          state_q, state_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [IW-1:0]   cand_q, cand_d;
    logic [CW-1:0]   iter_d;
    logic            busy_d, done_d, timeout_d;
    logic [IW-1:0]   idx_d;

    logic [N-1:0]    act;
    logic            onehot;
    logic [IW-1:0]   enc;

    logic [SW-1:0]   samp_streak;
    logic [IW-1:0]   samp_cand;
    logic [CW-1:0]   samp_iter;

    onehot_resolve #(
        .N (N),
        .W (W)
    ) u_resolve (
        .in_data (in_data),
        .act     (act),
        .onehot  (onehot),
        .enc     (enc)
    );

    // Effect of accepting the current sample on candidate, streak and iteration count.
    always_comb begin
        samp_cand   = cand_q;
        samp_streak = '0;
        if (onehot && (enc == cand_q) && (streak_q != '0)) begin
            samp_streak = (streak_q == SW'(STABLE)) ? streak_q : streak_q + SW'(1);
        end else if (onehot) begin
            samp_cand   = enc;
            samp_streak = SW'(1);
        end
        samp_iter = (iter_count == CW'(MAX_ITER)) ? iter_count : iter_count + CW'(1);
    end

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        cand_d    = cand_q;
        iter_d    = iter_count;
        done_d    = done;
        timeout_d = timeout;
        idx_d     = idx;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = TRACK;
                    streak_d  = '0;
                    iter_d    = '0;
                    timeout_d = 1'b0;
                    idx_d     = '0;
                end
            end
            TRACK: begin
                if (in_valid) begin
                    iter_d   = samp_iter;
                    streak_d = samp_streak;
                    cand_d   = samp_cand;
                    // A winner on the final permitted sample beats the timeout.
                    if (samp_streak == SW'(STABLE)) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b0;
                        idx_d     = samp_cand;
                    end else if (samp_iter == CW'(MAX_ITER)) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                        idx_d     = '0;
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    done_d = 1'b0;
                    if (start) begin
                        state_d   = TRACK;
                        streak_d  = '0;
                        iter_d    = '0;
                        timeout_d = 1'b0;
                        idx_d     = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == TRACK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            cand_q     <= '0;
            iter_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            idx        <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            cand_q     <= cand_d;
            iter_count <= iter_d;
            busy       <= busy_d;
            done       <= done_d;
            timeout    <= timeout_d;
            idx        <= idx_d;
        end
    end

    // The resolver's onehot flag must agree with its activity vector.
    a_onehot_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        onehot == $onehot(act));

endmodule

// File: tb/tb_winner_detect_seq.sv
// Directed bench for winner_detect_seq with a result scoreboard popped on each rising done.
module tb_winner_detect_seq;

    localparam int unsigned N        = 4;
    localparam int unsigned W        = 5;
    localparam int unsigned STABLE   = 3;
    localparam int unsigned MAX_ITER = 8;
    localparam int unsigned IW       = 2;
    localparam int unsigned CW       = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           in_valid;
    logic [N*W-1:0] in_data;
    logic           ack;
    logic           busy;
    logic           done;
    logic           timeout;
    logic [IW-1:0]  idx;
    logic [CW-1:0]  iter_count;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          timeout;
        logic [CW-1:0] iter;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic        done_prev = 1'b0;

    winner_detect_seq #(
        .N        (N),
        .W        (W),
        .STABLE   (STABLE),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .idx        (idx),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [N*W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        in_data  = '1;
        tick();
        in_data  = '0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic expect_result(input int unsigned i, input logic t, input int unsigned n);
        exp_t e;
        e.idx     = IW'(i);
        e.timeout = t;
        e.iter    = CW'(n);
        sb_q.push_back(e);
    endtask

    function automatic logic [N*W-1:0] ch(input int c, input logic [W-1:0] v);
        logic [N*W-1:0] r;
        r = '0;
        r[c*W +: W] = v;
        return r;
    endfunction

    // Monitor: each rising done must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = sb_q.pop_front();
                check("mon_idx", 32'(idx), 32'(e.idx));
                check("mon_timeout", 32'(timeout), 32'(e.timeout));
                check("mon_iter_count", 32'(iter_count), 32'(e.iter));
            end
        end
        done_prev = done;
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ack      = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_idx", 32'(idx), 0);
        check("rst_iter", 32'(iter_count), 0);
        rst_n = 1'b1;
        tick();

        // Clean win on channel 2, hold, stray start, then ack.
        expect_result(2, 1'b0, 3);
        go();
        check("t1_busy", 32'(busy), 1);
        check("t1_iter0", 32'(iter_count), 0);
        sample(ch(2, 5'h07));
        sample(ch(2, 5'h07));
        check("t1_not_yet", 32'(done), 0);
        check("t1_iter2", 32'(iter_count), 2);
        sample(ch(2, 5'h07));
        check("t1_done_edge", 32'(done), 1);
        check("t1_busy_low", 32'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("t1_hold_done", 32'(done), 1);
        check("t1_hold_idx", 32'(idx), 2);
        check("t1_hold_iter", 32'(iter_count), 3);
        do_ack();
        check("t1_ack_done", 32'(done), 0);
        check("t1_ack_busy", 32'(busy), 0);
        sample(ch(1, 5'h01));
        sample(ch(1, 5'h01));
        sample(ch(1, 5'h01));
        check("idle_ignores_valid", 32'(done), 0);
        check("idle_iter_held", 32'(iter_count), 3);

        // Multi-hot sample breaks the streak.
        expect_result(1, 1'b0, 6);
        go();
        sample(ch(1, 5'h10));
        sample(ch(1, 5'h10));
        sample(ch(1, 5'h10) | ch(3, 5'h01));
        sample(ch(1, 5'h10));
        sample(ch(1, 5'h10));
        check("t2_not_yet", 32'(done), 0);
        sample(ch(1, 5'h10));
        check("t2_done", 32'(done), 1);
        do_ack();

        // Candidate switch with bubbles carrying garbage data.
        expect_result(3, 1'b0, 5);
        go();
        sample(ch(0, 5'h01));
        bubble();
        check("t3_bubble_iter", 32'(iter_count), 1);
        sample(ch(0, 5'h01));
        bubble();
        sample(ch(3, 5'h1F));
        bubble();
        bubble();
        sample(ch(3, 5'h1F));
        bubble();
        check("t3_not_yet", 32'(done), 0);
        check("t3_iter4", 32'(iter_count), 4);
        sample(ch(3, 5'h1F));
        check("t3_done", 32'(done), 1);
        do_ack();

        // Timeout after MAX_ITER all-zero samples.
        expect_result(0, 1'b1, 8);
        go();
        repeat (7) sample('0);
        check("t4_not_yet", 32'(done), 0);
        sample('0);
        check("t4_done", 32'(done), 1);
        check("t4_timeout", 32'(timeout), 1);
        do_ack();

        // Winner reached exactly on the last permitted sample.
        expect_result(1, 1'b0, 8);
        go();
        repeat (5) sample('0);
        repeat (3) sample(ch(1, 5'h02));
        check("t5_done", 32'(done), 1);
        check("t5_timeout", 32'(timeout), 0);

        // Back-to-back: ack and start together.
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        check("b2b_done", 32'(done), 0);
        check("b2b_busy", 32'(busy), 1);
        check("b2b_iter", 32'(iter_count), 0);
        expect_result(0, 1'b0, 3);
        repeat (3) sample(ch(0, 5'h01));
        check("b2b_win", 32'(done), 1);
        do_ack();

        // Reset in the middle of a run.
        go();
        sample(ch(1, 5'h04));
        sample(ch(1, 5'h04));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_timeout", 32'(timeout), 0);
        check("mid_rst_idx", 32'(idx), 0);
        check("mid_rst_iter", 32'(iter_count), 0);
        expect_result(1, 1'b0, 3);
        go();
        sample(ch(1, 5'h04));
        sample(ch(1, 5'h04));
        check("t6_not_yet", 32'(done), 0);
        sample(ch(1, 5'h04));
        check("t6_done", 32'(done), 1);
        do_ack();

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
